// File: rtl/sd_buffer_pair.sv
// Two independent srdy/drdy flow-control channels sharing clock and reset:
//   channel F: synchronous FIFO (sd_fifo_s), f_depth entries deep
//   channel H: one-entry half-throughput register slice (sd_iohalf)
// Neither channel has a combinational path from srdy to drdy.

// Synchronous single-clock FIFO with extra-MSB pointers for full/empty.
module sd_fifo_s #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  localparam int unsigned Aw = $clog2(depth);
  localparam logic [Aw:0] PtrOne = {{Aw{1'b0}}, 1'b1};

  logic [width-1:0] mem_q [depth];
  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // Status flags, handshake qualification and next pointers.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]) && (wr_ptr_q[Aw] != rd_ptr_q[Aw]);
    c_drdy   = !full;
    p_srdy   = !empty;
    wr_en    = c_srdy && !full;
    rd_en    = p_drdy && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;
    // Head of queue straight from storage: no bypass when empty.
    p_data   = mem_q[rd_ptr_q[Aw-1:0]];
  end

  // Pointer registers; only pointers are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write on an accepted producer handshake.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= c_data;
    end
  end

endmodule

// One-entry register slice: alternates between accepting and presenting,
// so at most one word every two cycles and all outputs come from flops.
module sd_iohalf #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  logic             full_q, full_d;
  logic [width-1:0] data_q;
  logic             load;

  // Load when empty, unload when full; the two never coincide.
  always_comb begin
    c_drdy = !full_q;
    p_srdy = full_q;
    p_data = data_q;
    load   = c_srdy && !full_q;
    full_d = full_q;
    if (load) begin
      full_d = 1'b1;
    end else if (p_drdy && full_q) begin
      full_d = 1'b0;
    end
  end

  // Occupancy flag, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Data register, not reset.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= c_data;
    end
  end

endmodule

// Top-level wrapper: the two channels are fully independent.
module sd_buffer_pair #(
  parameter int unsigned f_width = 8,
  parameter int unsigned f_depth = 4,
  parameter int unsigned h_width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fc_srdy,
  output logic               fc_drdy,
  input  logic [f_width-1:0] fc_data,
  output logic               fp_srdy,
  input  logic               fp_drdy,
  output logic [f_width-1:0] fp_data,
  input  logic               hc_srdy,
  output logic               hc_drdy,
  input  logic [h_width-1:0] hc_data,
  output logic               hp_srdy,
  input  logic               hp_drdy,
  output logic [h_width-1:0] hp_data
);

  sd_fifo_s #(
    .width (f_width),
    .depth (f_depth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (fc_srdy),
    .c_drdy (fc_drdy),
    .c_data (fc_data),
    .p_srdy (fp_srdy),
    .p_drdy (fp_drdy),
    .p_data (fp_data)
  );

  sd_iohalf #(
    .width (h_width)
  ) u_half (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (hc_srdy),
    .c_drdy (hc_drdy),
    .c_data (hc_data),
    .p_srdy (hp_srdy),
    .p_drdy (hp_drdy),
    .p_data (hp_data)
  );

endmodule

// File: tb/tb_sd_buffer_pair.sv
// Bench for sd_buffer_pair: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_sd_buffer_pair;

  localparam int unsigned FDepth = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       fc_srdy, fc_drdy, fp_srdy, fp_drdy;
  logic [7:0] fc_data, fp_data;
  logic       hc_srdy, hc_drdy, hp_srdy, hp_drdy;
  logic [7:0] hc_data, hp_data;

  int checks = 0;
  int failures = 0;

  sd_buffer_pair #(
    .f_width (8),
    .f_depth (FDepth),
    .h_width (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fc_srdy (fc_srdy),
    .fc_drdy (fc_drdy),
    .fc_data (fc_data),
    .fp_srdy (fp_srdy),
    .fp_drdy (fp_drdy),
    .fp_data (fp_data),
    .hc_srdy (hc_srdy),
    .hc_drdy (hc_drdy),
    .hc_data (hc_data),
    .hp_srdy (hp_srdy),
    .hp_drdy (hp_drdy),
    .hp_data (hp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fcs, input logic [7:0] fcd, input logic fpd,
                       input logic hcs, input logic [7:0] hcd, input logic hpd);
    fc_srdy = fcs;
    fc_data = fcd;
    fp_drdy = fpd;
    hc_srdy = hcs;
    hc_data = hcd;
    hp_drdy = hpd;
  endtask

  // Inputs applied for one cycle and the outputs expected before that edge.
  typedef struct {
    logic       fcs;
    logic [7:0] fcd;
    logic       fpd;
    logic       hcs;
    logic [7:0] hcd;
    logic       hpd;
    logic       e_fcdr;
    logic       e_fps;
    logic [7:0] e_fpd;
    logic       e_hcdr;
    logic       e_hps;
    logic [7:0] e_hpd;
  } vec_t;

  vec_t vecs [13];

  // Reference model state.
  logic [7:0] fq [$];
  logic       h_full;
  logic [7:0] h_data;

  initial begin
    // fcs fcd fpd | hcs hcd hpd | fc_drdy fp_srdy fp_data | hc_drdy hp_srdy hp_data
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5};
    // Full: 0x55 must be refused.
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5};
    // Full with read and write together: only the read happens.
    vecs[6]  = '{1'b1, 8'h66, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'hA5};
    vecs[7]  = '{1'b1, 8'h66, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h5A};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: fill, refuse, full-boundary read, drain, H hold.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].fcs, vecs[i].fcd, vecs[i].fpd, vecs[i].hcs, vecs[i].hcd, vecs[i].hpd);
      #1;
      check($sformatf("vec%0d fc_drdy", i), 32'(fc_drdy), 32'(vecs[i].e_fcdr));
      check($sformatf("vec%0d fp_srdy", i), 32'(fp_srdy), 32'(vecs[i].e_fps));
      if (vecs[i].e_fps) check($sformatf("vec%0d fp_data", i), 32'(fp_data), 32'(vecs[i].e_fpd));
      check($sformatf("vec%0d hc_drdy", i), 32'(hc_drdy), 32'(vecs[i].e_hcdr));
      check($sformatf("vec%0d hp_srdy", i), 32'(hp_srdy), 32'(vecs[i].e_hps));
      if (vecs[i].e_hps) check($sformatf("vec%0d hp_data", i), 32'(hp_data), 32'(vecs[i].e_hpd));
      @(negedge clk);
    end

    // Reset with F holding two entries and H full.
    drive(1'b1, 8'h77, 1'b0, 1'b1, 8'h99, 1'b0);
    @(negedge clk);
    fc_data = 8'h78;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check("pre-reset fp_srdy", 32'(fp_srdy), 32'd1);
    check("pre-reset hp_srdy", 32'(hp_srdy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset fp_srdy", 32'(fp_srdy), 32'd0);
    check("post-reset fc_drdy", 32'(fc_drdy), 32'd1);
    check("post-reset hp_srdy", 32'(hp_srdy), 32'd0);
    check("post-reset hc_drdy", 32'(hc_drdy), 32'd1);
    @(negedge clk);

    // F streaming: 20 words back to back, pointers wrap several times.
    for (int k = 0; k <= 20; k++) begin
      drive(k < 20, 8'(k), 1'b1, 1'b0, 8'h00, 1'b0);
      #1;
      check($sformatf("stream%0d fc_drdy", k), 32'(fc_drdy), 32'd1);
      check($sformatf("stream%0d fp_srdy", k), 32'(fp_srdy), 32'(k >= 1));
      if (k >= 1) check($sformatf("stream%0d fp_data", k), 32'(fp_data), 32'(k - 1));
      @(negedge clk);
    end

    // H alternation with continuous srdy/drdy: accepts every other cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, (((i / 2) % 2) != 0) ? 8'h5A : 8'hA5, 1'b1);
      #1;
      check($sformatf("halt%0d hc_drdy", i), 32'(hc_drdy), 32'((i % 2) == 0));
      check($sformatf("halt%0d hp_srdy", i), 32'(hp_srdy), 32'((i % 2) == 1));
      if ((i % 2) == 1)
        check($sformatf("halt%0d hp_data", i), 32'(hp_data),
              ((((i - 1) / 2) % 2) != 0) ? 32'h5A : 32'hA5);
      @(negedge clk);
    end

    // Randomized run against the reference model, from a clean reset.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fq.delete();
    h_full = 1'b0;
    h_data = 8'h00;
    for (int c = 0; c < 1000; c++) begin
      logic fcs, fpd, hcs, hpd;
      logic [7:0] fcd, hcd;
      logic f_wr, f_rd;
      fcs = 1'($urandom_range(0, 1));
      fpd = 1'($urandom_range(0, 1));
      hcs = 1'($urandom_range(0, 1));
      hpd = 1'($urandom_range(0, 1));
      fcd = 8'($urandom);
      hcd = 8'($urandom);
      drive(fcs, fcd, fpd, hcs, hcd, hpd);
      #1;
      check("rnd fc_drdy", 32'(fc_drdy), 32'(fq.size() < FDepth));
      check("rnd fp_srdy", 32'(fp_srdy), 32'(fq.size() > 0));
      if (fq.size() > 0) check("rnd fp_data", 32'(fp_data), 32'(fq[0]));
      check("rnd hc_drdy", 32'(hc_drdy), 32'(!h_full));
      check("rnd hp_srdy", 32'(hp_srdy), 32'(h_full));
      if (h_full) check("rnd hp_data", 32'(hp_data), 32'(h_data));
      // Model update for the coming edge, decided on pre-edge occupancy.
      f_wr = fcs && (fq.size() < FDepth);
      f_rd = fpd && (fq.size() > 0);
      if (f_rd) void'(fq.pop_front());
      if (f_wr) fq.push_back(fcd);
      if (h_full) begin
        if (hpd) h_full = 1'b0;
      end else if (hcs) begin
        h_full = 1'b1;
        h_data = hcd;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
